spi_slave_responder: RTL and testbench
======================================

// Module: spi_slave_responder
// PURPOSE
//  SPI mode-0 responder (target) for the on-chip SPI master's frame format: 32-bit header
//  {cmd[7:0], addr[23:0]}, MSB first, then a variable-length data phase, all framed by CS.
//  Decodes write/read commands and presents them to a simple register/memory backend port.
//  Used as a loopback target for master verification and as the peripheral end of SoC links.
//  SCK/CS/MOSI are asynchronous to clk; they are oversampled through synchronizers.
// PARAMETERS
//  CMD_WRITE    8'h02  header command byte that selects a write transaction
//  CMD_READ     8'h03  header command byte that selects a read transaction
//  SYNC_STAGES  2      flop stages on spi_clk, spi_cs_n and spi_mosi (2 or 3)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous active-low reset
//  spi_clk    in   1   SPI clock from master, idle low; clk must be >= 8x its frequency
//  spi_cs_n   in   1   chip select, active low
//  spi_mosi   in   1   master-out data, sampled on SCK rising edge
//  spi_miso   out  1   slave-out data, updated on SCK falling edge
//  wr_valid   out  1   one-cycle pulse: completed write transaction
//  wr_addr    out  24  write address (header addr)
//  wr_data    out  32  received write bits, right-aligned, first bit most significant
//  wr_bits    out  6   number of valid bits in wr_data (1..32)
//  rd_req     out  1   one-cycle pulse: read data requested
//  rd_addr    out  24  read address (header addr)
//  rd_data    in   32  read data; must be valid the cycle after rd_req
//  busy       out  1   high while a frame is in progress (synced CS low)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; shift registers and counters cleared.
//  Edge detect on synchronized signals: rise/fall of SCK, rise of CS. SCK edges ignored while CS high.
//  States: IDLE, HDR, WDATA, RDATA, IGNORE.
//  IDLE: synced CS falls -> HDR, bit_cnt=0, spi_miso=0. busy=1 from that cycle until return to IDLE.
//  HDR: each SCK rise shifts MOSI into hdr[0], bit_cnt++. At 32nd rise: latch addr;
//   cmd==CMD_WRITE -> WDATA; cmd==CMD_READ -> pulse rd_req with rd_addr, -> RDATA;
//   else -> IGNORE. bit_cnt reset to 0 on entry to every data state.
//  RDATA: cycle after rd_req, load rd_data into tx shift reg. Each SCK fall drives tx[31]
//   onto spi_miso and shifts left (zero fill); after 32 bits spi_miso stays 0.
//  WDATA: each SCK rise shifts MOSI into wr shift reg LSB; bit_cnt saturates at 32; beyond
//   32 bits the last 32 received are kept.
//  IGNORE: SCK ignored, spi_miso=0, wait for CS.
//  CS rise (any non-IDLE state) -> IDLE, spi_miso=0 same cycle. If leaving WDATA with
//   bit_cnt>=1: pulse wr_valid with wr_addr, wr_data, wr_bits=bit_cnt (32 encoded as 6'd32).
//   WDATA with 0 bits, HDR (short header), RDATA, IGNORE: no wr_valid pulse (abort).
//  wr_addr/wr_data/wr_bits/rd_addr hold value until next update; pulses never coincide.
//  CS fall and rise in same synced sample impossible; CS rise same cycle as SCK edge: CS wins.
//  Latency: wr_valid at most SYNC_STAGES+2 clk after CS pin rises.
//  Async reset mid-frame: immediate return to IDLE, no pulses; next frame needs a new CS fall.
// TESTING
//  1 CS low, header 0x02000010, data 0xDEADBEEF (32 bits), CS high -> one wr_valid,
//    wr_addr=0x000010, wr_data=0xDEADBEEF, wr_bits=32; rd_req never asserted.
//  2 Header 0x03000020, rd_data=0x12345678 -> one rd_req, rd_addr=0x000020; 32 clocked bits
//    on MISO read back by master as 0x12345678; then 0 on MISO.
//  3 Header 0x02000004, 8 data bits 0xA5 -> wr_data=0x000000A5, wr_bits=8.
//  4 CS high after 16 header bits; and header 0xAB000000 + 32 bits -> no wr_valid/rd_req,
//    MISO=0 throughout, busy low after CS high.
//  5 rst_n low during WDATA bit 10 -> all outputs 0, no wr_valid; next full write (case 1) succeeds.
//  6 Back-to-back frames (write then read, 1 SCK period CS high gap) -> each decoded correctly.

Source files
------------

// File: rtl/spi_slave_responder.sv
// SPI mode-0 target: 32-bit {cmd,addr} header, then write or read data.
// Pins are oversampled through synchronizers in the clk domain.
module spi_slave_responder #(
  parameter logic [7:0] CMD_WRITE   = 8'h02,
  parameter logic [7:0] CMD_READ    = 8'h03,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_clk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        wr_valid,
  output logic [23:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [5:0]  wr_bits,
  output logic        rd_req,
  output logic [23:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, HDR, WDATA, RDATA, IGNORE
  } state_e;

  localparam int SW = SYNC_STAGES;

  logic [SW-1:0] sck_sync_q, sck_sync_d;
  logic [SW-1:0] cs_sync_q, cs_sync_d;
  logic [SW-1:0] mosi_sync_q, mosi_sync_d;
  logic          sck_prev_q, sck_prev_d;
  logic          cs_prev_q, cs_prev_d;

  state_e        state_q, state_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [30:0]   hdr_q, hdr_d;
  logic [23:0]   addr_q, addr_d;
  logic [31:0]   wr_sr_q, wr_sr_d;
  logic [31:0]   tx_q, tx_d;
  logic          load_q, load_d;
  logic          miso_q, miso_d;
  logic          wr_valid_q, wr_valid_d;
  logic [23:0]   wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic [5:0]    wr_bits_q, wr_bits_d;
  logic          rd_req_q, rd_req_d;
  logic [23:0]   rd_addr_q, rd_addr_d;

  logic          sck_s, cs_s, mosi_s;
  logic          sck_rise, sck_fall;
  logic          cs_rise, cs_fall;
  logic [31:0]   hdr_next;
  logic [31:0]   tx_cur;

  assign sck_s  = sck_sync_q[SW-1];
  assign cs_s   = cs_sync_q[SW-1];
  assign mosi_s = mosi_sync_q[SW-1];

  // SCK edges only count while the synced CS is asserted
  assign sck_rise = sck_s & ~sck_prev_q & ~cs_s;
  assign sck_fall = ~sck_s & sck_prev_q & ~cs_s;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  assign hdr_next = {hdr_q, mosi_s};
  assign tx_cur   = load_q ? rd_data : tx_q;

  always_comb begin
    sck_sync_d  = {sck_sync_q[SW-2:0], spi_clk};
    cs_sync_d   = {cs_sync_q[SW-2:0], spi_cs_n};
    mosi_sync_d = {mosi_sync_q[SW-2:0], spi_mosi};
    sck_prev_d  = sck_s;
    cs_prev_d   = cs_s;
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    hdr_d      = hdr_q;
    addr_d     = addr_q;
    wr_sr_d    = wr_sr_q;
    tx_d       = tx_q;
    load_d     = rd_req_q;
    miso_d     = miso_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_bits_d  = wr_bits_q;
    rd_req_d   = 1'b0;
    rd_addr_d  = rd_addr_q;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = HDR;
          bit_cnt_d = '0;
          hdr_d     = '0;
          miso_d    = 1'b0;
        end
      end
      HDR: begin
        if (cs_rise) begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end else if (sck_rise) begin
          hdr_d     = hdr_next[30:0];
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'd31) begin
            addr_d    = hdr_next[23:0];
            bit_cnt_d = '0;
            unique case (1'b1)
              hdr_next[31:24] == CMD_WRITE: begin
                state_d = WDATA;
                wr_sr_d = '0;
              end
              hdr_next[31:24] == CMD_READ: begin
                state_d   = RDATA;
                rd_req_d  = 1'b1;
                rd_addr_d = hdr_next[23:0];
              end
              default: state_d = IGNORE;
            endcase
          end
        end
      end
      WDATA: begin
        if (cs_rise) begin
          state_d = IDLE;
          miso_d  = 1'b0;
          if (bit_cnt_q != 6'd0) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = wr_sr_q;
            wr_bits_d  = bit_cnt_q;
          end
        end else if (sck_rise) begin
          wr_sr_d = {wr_sr_q[30:0], mosi_s};
          if (bit_cnt_q != 6'd32) bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
      RDATA: begin
        tx_d = tx_cur;
        if (cs_rise) begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end else if (sck_fall) begin
          miso_d = tx_cur[31];
          tx_d   = {tx_cur[30:0], 1'b0};
        end
      end
      IGNORE: begin
        if (cs_rise) begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      hdr_q       <= '0;
      addr_q      <= '0;
      wr_sr_q     <= '0;
      tx_q        <= '0;
      load_q      <= 1'b0;
      miso_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_bits_q   <= '0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      hdr_q       <= hdr_d;
      addr_q      <= addr_d;
      wr_sr_q     <= wr_sr_d;
      tx_q        <= tx_d;
      load_q      <= load_d;
      miso_q      <= miso_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_bits_q   <= wr_bits_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign spi_miso = miso_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_bits  = wr_bits_q;
  assign rd_req   = rd_req_q;
  assign rd_addr  = rd_addr_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: a behavioural SPI master
// plus a backend monitor that counts and captures the output pulses.
module tb_spi_slave_responder;

  localparam int HALF = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic [31:0] rd_data = '0;
  logic        spi_miso;
  logic        wr_valid;
  logic [23:0] wr_addr;
  logic [31:0] wr_data;
  logic [5:0]  wr_bits;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;

  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          both_cnt = 0;
  int          miso_ones = 0;
  logic [23:0] cap_waddr = '0;
  logic [31:0] cap_wdata = '0;
  logic [5:0]  cap_wbits = '0;
  logic [23:0] cap_raddr = '0;
  logic [31:0] rd_resp = '0;
  time         wr_t = 0;
  time         cs_t = 0;

  spi_slave_responder #(
    .CMD_WRITE(8'h02),
    .CMD_READ(8'h03),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .spi_clk(spi_clk),
    .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .wr_valid(wr_valid),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_bits(wr_bits),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // backend: answers rd_req one cycle later, records pulses
  always @(negedge clk) begin
    if (wr_valid) begin
      wr_cnt++;
      cap_waddr = wr_addr;
      cap_wdata = wr_data;
      cap_wbits = wr_bits;
      wr_t = $time;
    end
    if (rd_req) begin
      rd_cnt++;
      cap_raddr = rd_addr;
      rd_data = rd_resp;
    end
    if (wr_valid && rd_req) both_cnt++;
    if (spi_miso !== 1'b0) miso_ones++;
  end

  task automatic cs_start();
    @(negedge clk);
    spi_cs_n = 1'b0;
    #(HALF);
  endtask

  task automatic shift(input logic [63:0] v, input int n,
                       output logic [63:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = v[n-1-i];
      #(HALF);
      rx = {rx[62:0], spi_miso};
      spi_clk = 1'b1;
      #(HALF);
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_end(input int gap, output logic tail);
    spi_mosi = 1'b0;
    #(HALF);
    tail = spi_miso;
    spi_cs_n = 1'b1;
    cs_t = $time;
    #(gap);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({spi_miso, wr_valid, rd_req, busy} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b exp 0000",
               {spi_miso, wr_valid, rd_req, busy});
    end
    n_checks++;
    if ({wr_addr, wr_data, wr_bits, rd_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h/%0d/%h exp 0",
               wr_addr, wr_data, wr_bits, rd_addr);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    logic [63:0] rx;
    logic        tail;
    int          w0, r0;
    w0 = wr_cnt;
    r0 = rd_cnt;
    cs_start();
    shift(64'h0200_0010, 32, rx);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_busy: got %b exp 1", busy);
    end
    shift(64'hDEAD_BEEF, 32, rx);
    cs_end(300, tail);
    n_checks++;
    if (wr_cnt !== w0 + 1) begin
      n_fail++;
      $display("FAIL wr_pulses: got %0d exp %0d", wr_cnt - w0, 1);
    end
    n_checks++;
    if (cap_waddr !== 24'h000010 || wr_addr !== 24'h000010) begin
      n_fail++;
      $display("FAIL wr_addr: got %h exp 000010", cap_waddr);
    end
    n_checks++;
    if (cap_wdata !== 32'hDEAD_BEEF || wr_data !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL wr_data: got %h exp deadbeef", cap_wdata);
    end
    n_checks++;
    if (cap_wbits !== 6'd32) begin
      n_fail++;
      $display("FAIL wr_bits: got %0d exp 32", cap_wbits);
    end
    n_checks++;
    if (rd_cnt !== r0) begin
      n_fail++;
      $display("FAIL wr_no_rd: got %0d exp 0", rd_cnt - r0);
    end
    n_checks++;
    if (wr_t - cs_t > 40 || wr_t < cs_t) begin
      n_fail++;
      $display("FAIL wr_latency: got %0t exp <= 40", wr_t - cs_t);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_idle: got busy %b exp 0", busy);
    end
  endtask

  task automatic test_read(input logic [23:0] a, input logic [31:0] d,
                           input int gap);
    logic [63:0] rx;
    logic        tail;
    int          w0, r0;
    w0 = wr_cnt;
    r0 = rd_cnt;
    rd_resp = d;
    cs_start();
    shift({32'h0, 8'h03, a}, 32, rx);
    shift(64'h0, 32, rx);
    cs_end(gap, tail);
    n_checks++;
    if (rd_cnt !== r0 + 1 || cap_raddr !== a) begin
      n_fail++;
      $display("FAIL rd_req: got %0d pulses addr %h exp 1 addr %h",
               rd_cnt - r0, cap_raddr, a);
    end
    n_checks++;
    if (rx[31:0] !== d) begin
      n_fail++;
      $display("FAIL rd_miso: got %h exp %h", rx[31:0], d);
    end
    n_checks++;
    if (tail !== 1'b0 || spi_miso !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_tail: got %b exp 0", tail);
    end
    n_checks++;
    if (wr_cnt !== w0) begin
      n_fail++;
      $display("FAIL rd_no_wr: got %0d exp 0", wr_cnt - w0);
    end
  endtask

  task automatic test_short_write();
    logic [63:0] rx;
    logic        tail;
    cs_start();
    shift(64'h0200_0004, 32, rx);
    shift(64'hA5, 8, rx);
    cs_end(300, tail);
    n_checks++;
    if (cap_wdata !== 32'h0000_00A5 || cap_wbits !== 6'd8 ||
        cap_waddr !== 24'h000004) begin
      n_fail++;
      $display("FAIL wr8: got %h/%0d/%h exp a5/8/000004",
               cap_wdata, cap_wbits, cap_waddr);
    end
  endtask

  task automatic test_overflow();
    logic [63:0] rx;
    logic        tail;
    int          w0;
    w0 = wr_cnt;
    cs_start();
    shift(64'h0200_0008, 32, rx);
    shift(64'h11_2233_4455, 40, rx);
    cs_end(300, tail);
    n_checks++;
    if (wr_cnt !== w0 + 1 || cap_wdata !== 32'h2233_4455 ||
        cap_wbits !== 6'd32) begin
      n_fail++;
      $display("FAIL wr40: got %0d/%h/%0d exp 1/22334455/32",
               wr_cnt - w0, cap_wdata, cap_wbits);
    end
    w0 = wr_cnt;
    cs_start();
    shift(64'h0200_0008, 32, rx);
    cs_end(300, tail);
    n_checks++;
    if (wr_cnt !== w0) begin
      n_fail++;
      $display("FAIL wr0: got %0d pulses exp 0", wr_cnt - w0);
    end
  endtask

  task automatic test_abort();
    logic [63:0] rx;
    logic        tail;
    int          w0, r0, m0;
    w0 = wr_cnt;
    r0 = rd_cnt;
    m0 = miso_ones;
    cs_start();
    shift(64'h0200_0010, 16, rx);
    cs_end(300, tail);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy: got %b exp 0", busy);
    end
    cs_start();
    shift(64'hAB00_0000, 32, rx);
    shift(64'hFFFF_FFFF, 32, rx);
    cs_end(300, tail);
    n_checks++;
    if (wr_cnt !== w0 || rd_cnt !== r0) begin
      n_fail++;
      $display("FAIL abort_pulses: got wr %0d rd %0d exp 0 0",
               wr_cnt - w0, rd_cnt - r0);
    end
    n_checks++;
    if (miso_ones !== m0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_miso: got %0d ones busy %b exp 0 0",
               miso_ones - m0, busy);
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] rx;
    logic        tail;
    int          w0;
    w0 = wr_cnt;
    cs_start();
    shift(64'h0200_0040, 32, rx);
    shift(64'h3FF, 10, rx);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({spi_miso, wr_valid, rd_req, busy, wr_addr, wr_data, wr_bits,
         rd_addr} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got busy %b wr_addr %h wr_data %h",
               busy, wr_addr, wr_data);
    end
    rst_n = 1'b1;
    shift(64'h3F_FFFF, 22, rx);
    cs_end(300, tail);
    n_checks++;
    if (wr_cnt !== w0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_pulse: got %0d busy %b exp 0 0",
               wr_cnt - w0, busy);
    end
    test_write();
  endtask

  task automatic test_back_to_back();
    logic [63:0] rx;
    logic        tail;
    int          w0;
    w0 = wr_cnt;
    cs_start();
    shift(64'h0200_0100, 32, rx);
    shift(64'hCAFE_F00D, 32, rx);
    cs_end(2 * HALF, tail);
    test_read(24'h000200, 32'h0BAD_C0DE, 300);
    n_checks++;
    if (wr_cnt !== w0 + 1 || cap_wdata !== 32'hCAFE_F00D ||
        cap_waddr !== 24'h000100) begin
      n_fail++;
      $display("FAIL b2b_write: got %0d/%h/%h exp 1/cafef00d/000100",
               wr_cnt - w0, cap_wdata, cap_waddr);
    end
    n_checks++;
    if (both_cnt !== 0) begin
      n_fail++;
      $display("FAIL pulse_overlap: got %0d exp 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read(24'h000020, 32'h1234_5678, 300);
    test_short_write();
    test_overflow();
    test_abort();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
